// File: rtl/ann_label_trainer26.sv
// Training sequencer for the 26-neuron learning layer: settle, serial argmax scan, optional teach pulse.
// Optional build macro ANN_TRAINER_STATS_EN adds saturating sample/correct counters cleared by i_stats_clr.
module ann_label_trainer26 #(
   parameter int SETTLE = 2,
   parameter int CNT_W  = 16,
   parameter int VAL_W  = 8
) (
   input  logic                    i_clock,
   input  logic                    i_reset_n,
   input  logic                    i_start,
   input  logic [4:0]              i_label,
   input  logic                    i_train,
   output logic                    o_busy,
   output logic                    o_done,
   output logic                    o_label_err,
   input  logic [25:0][VAL_W-1:0]  i_layer_out,
   output logic                    o_valid,
   output logic                    o_learn,
   output logic [25:0][VAL_W-1:0]  o_expected_out,
   output logic [4:0]              o_predicted,
   output logic                    o_correct,
   input  logic                    i_stats_clr,
   output logic [CNT_W-1:0]        o_sample_count,
   output logic [CNT_W-1:0]        o_correct_count
);

   typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_SCAN, S_TEACH, S_DONE} state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic [3:0]               r_cnt;
   logic [4:0]               r_idx;
   logic [4:0]               r_label;
   logic                     r_train;
   logic [VAL_W-1:0]         r_best_val;
   logic [4:0]               r_best_idx;
   logic                     r_busy, r_done, r_label_err, r_valid, r_learn, r_correct;
   logic [4:0]               r_predicted;
   logic [25:0][VAL_W-1:0]   r_expected;
   logic                     w_accept;
   logic                     w_take;
   logic [VAL_W-1:0]         w_elem;
   logic [4:0]               w_fin_idx;

   assign w_accept  = (r_state == S_IDLE) && i_start && (i_label <= 5'd25);
   assign w_elem    = i_layer_out[r_idx];
   // Strictly-greater update keeps the lowest index on ties; element 0 seeds the search.
   assign w_take    = (r_idx == 5'd0) || (w_elem > r_best_val);
   assign w_fin_idx = ((r_state == S_SCAN) && w_take) ? r_idx : r_best_idx;

   // State register.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) r_state <= S_IDLE;
      else            r_state <= w_state_nxt;
   end

   // Next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_accept) w_state_nxt = S_SETTLE; else w_state_nxt = S_IDLE;
         S_SETTLE: if (r_cnt == SETTLE_LAST) w_state_nxt = S_SCAN; else w_state_nxt = S_SETTLE;
         S_SCAN: begin
            if (r_idx == 5'd25) w_state_nxt = r_train ? S_TEACH : S_DONE;
            else                w_state_nxt = S_SCAN;
         end
         S_TEACH:  w_state_nxt = S_DONE;
         S_DONE:   w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // Sample capture, settle counter and running argmax.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_cnt      <= 4'd0;
         r_idx      <= 5'd0;
         r_label    <= 5'd0;
         r_train    <= 1'b0;
         r_best_val <= {VAL_W{1'b0}};
         r_best_idx <= 5'd0;
         r_expected <= {(26*VAL_W){1'b0}};
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_label             <= i_label;
                  r_train             <= i_train;
                  r_cnt               <= 4'd0;
                  r_idx               <= 5'd0;
                  r_expected          <= {(26*VAL_W){1'b0}};
                  r_expected[i_label] <= {VAL_W{1'b1}};
               end
            end
            S_SETTLE: r_cnt <= r_cnt + 4'd1;
            S_SCAN: begin
               if (w_take) begin
                  r_best_val <= w_elem;
                  r_best_idx <= r_idx;
               end
               r_idx <= r_idx + 5'd1;
            end
            default: ;
         endcase
      end
   end

   // Registered handshake/layer controls, decoded from the upcoming state.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_label_err <= 1'b0;
         r_valid     <= 1'b0;
         r_learn     <= 1'b0;
         r_predicted <= 5'd0;
         r_correct   <= 1'b0;
      end else begin
         r_busy      <= (w_state_nxt != S_IDLE);
         r_done      <= (w_state_nxt == S_DONE);
         r_label_err <= (r_state == S_IDLE) && i_start && (i_label > 5'd25);
         r_valid     <= (w_state_nxt == S_SETTLE) || (w_state_nxt == S_SCAN) ||
                        (w_state_nxt == S_TEACH);
         r_learn     <= (w_state_nxt == S_TEACH);
         if (w_state_nxt == S_DONE) begin
            r_predicted <= w_fin_idx;
            r_correct   <= (w_fin_idx == r_label);
         end
      end
   end

`ifdef ANN_TRAINER_STATS_EN
   logic [CNT_W-1:0] r_sample_cnt;
   logic [CNT_W-1:0] r_correct_cnt;

   // Saturating statistics; clear wins over a coincident increment.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_sample_cnt  <= {CNT_W{1'b0}};
         r_correct_cnt <= {CNT_W{1'b0}};
      end else if (i_stats_clr) begin
         r_sample_cnt  <= {CNT_W{1'b0}};
         r_correct_cnt <= {CNT_W{1'b0}};
      end else if (r_state == S_DONE) begin
         if (r_sample_cnt != {CNT_W{1'b1}}) r_sample_cnt <= r_sample_cnt + CNT_W'(1);
         if (r_correct && (r_correct_cnt != {CNT_W{1'b1}})) r_correct_cnt <= r_correct_cnt + CNT_W'(1);
      end
   end

   assign o_sample_count  = r_sample_cnt;
   assign o_correct_count = r_correct_cnt;
`else
   logic w_unused_stats_clr;
   assign w_unused_stats_clr = i_stats_clr;
   assign o_sample_count     = {CNT_W{1'b0}};
   assign o_correct_count    = {CNT_W{1'b0}};
`endif

   assign o_busy         = r_busy;
   assign o_done         = r_done;
   assign o_label_err    = r_label_err;
   assign o_valid        = r_valid;
   assign o_learn        = r_learn;
   assign o_expected_out = r_expected;
   assign o_predicted    = r_predicted;
   assign o_correct      = r_correct;

endmodule

// File: tb/tb_ann_label_trainer26.sv
// Self-checking bench for ann_label_trainer26: directed table, randomized samples against an argmax model,
// plus label error, busy-start, mid-scan reset and counter saturation/clear sequences.
module tb_ann_label_trainer26;

   localparam int SETTLE = 2;
   localparam int CNT_W  = 4;
   localparam int VAL_W  = 8;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic                   start = 1'b0;
   logic [4:0]             label = 5'd0;
   logic                   train = 1'b0;
   logic                   stats_clr = 1'b0;
   logic [25:0][VAL_W-1:0] layer = '0;
   logic                   busy, done, label_err, valid, learn, correct;
   logic [25:0][VAL_W-1:0] exp_out;
   logic [4:0]             predicted;
   logic [CNT_W-1:0]       sample_count, correct_count;

   int n_checks = 0;
   int n_fail   = 0;
   int m_samples = 0;
   int m_correct = 0;

   ann_label_trainer26 #(.SETTLE(SETTLE), .CNT_W(CNT_W), .VAL_W(VAL_W)) dut (
      .i_clock(clk), .i_reset_n(rst_n), .i_start(start), .i_label(label), .i_train(train),
      .o_busy(busy), .o_done(done), .o_label_err(label_err), .i_layer_out(layer),
      .o_valid(valid), .o_learn(learn), .o_expected_out(exp_out), .o_predicted(predicted),
      .o_correct(correct), .i_stats_clr(stats_clr), .o_sample_count(sample_count),
      .o_correct_count(correct_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] lab;
      bit         tr;
      logic [7:0] base;
      logic [4:0] p1;
      logic [4:0] p2;
      logic [7:0] pv;
      logic [4:0] exp_pred;
      bit         exp_corr;
   } vec_t;

   vec_t tbl[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   task automatic check_vec(input string name, input logic [25:0][VAL_W-1:0] act,
                            input logic [25:0][VAL_W-1:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   function automatic int sat_inc(input int v);
      return (v >= 15) ? 15 : v + 1;
   endfunction

   function automatic logic [4:0] model_argmax(input logic [25:0][VAL_W-1:0] v);
      int best = 0;
      for (int i = 1; i < 26; i++) if (v[i] > v[best]) best = i;
      return 5'(best);
   endfunction

   function automatic int exp_cnt(input int v);
`ifdef ANN_TRAINER_STATS_EN
      return v;
`else
      return 0 * v;
`endif
   endfunction

   task automatic set_pattern(input logic [7:0] base, input logic [4:0] p1, input logic [4:0] p2,
                              input logic [7:0] pv);
      for (int i = 0; i < 26; i++) layer[i] = base;
      layer[p1] = pv;
      layer[p2] = pv;
   endtask

   // One full sample: checks the cycle timeline, results and counters afterwards.
   task automatic run_sample(input logic [4:0] lab, input bit tr, input int stray_at,
                             input bit clr_at_done, input logic [4:0] exp_pred, input bit exp_corr);
      int done_at = 0, learn_at = 0, learn_n = 0, valid_bad = 0, busy_bad = 0, lerr_n = 0, extra_done = 0;
      logic [25:0][VAL_W-1:0] exp_vec;
      @(negedge clk);
      start = 1'b1; label = lab; train = tr;
      @(negedge clk);
      start = 1'b0;
      exp_vec = '0;
      exp_vec[lab] = 8'hFF;
      check_vec("expected_out", exp_out, exp_vec);
      for (int n = 1; n <= SETTLE + 40; n++) begin
         if (n == stray_at + 1) start = 1'b0;
         if (n == stray_at) begin start = 1'b1; label = 5'd30; end
         if (valid !== (n <= SETTLE + 26 + int'(tr))) valid_bad++;
         if (busy !== 1'b1) busy_bad++;
         if (learn === 1'b1) begin learn_n++; learn_at = n; end
         if (label_err === 1'b1) lerr_n++;
         if (done === 1'b1) begin done_at = n; break; end
         @(negedge clk);
      end
      start = 1'b0;
      check("done_cycle", done_at, SETTLE + 27 + int'(tr));
      check("learn_pulses", learn_n, int'(tr));
      check("learn_cycle", learn_at, tr ? SETTLE + 27 : 0);
      check("valid_profile_errs", valid_bad, 0);
      check("busy_profile_errs", busy_bad, 0);
      check("label_err_while_busy", lerr_n, 0);
      check("predicted", predicted, exp_pred);
      check("correct", correct, exp_corr);
      if (clr_at_done) begin
         stats_clr = 1'b1;
         m_samples = 0; m_correct = 0;
      end else begin
         m_samples = sat_inc(m_samples);
         if (exp_corr) m_correct = sat_inc(m_correct);
      end
      @(negedge clk);
      stats_clr = 1'b0;
      check("busy_after_done", busy, 0);
      check("sample_count", sample_count, exp_cnt(m_samples));
      check("correct_count", correct_count, exp_cnt(m_correct));
      for (int n = 0; n < 3; n++) begin
         if (done === 1'b1) extra_done++;
         @(negedge clk);
      end
      check("extra_done", extra_done, 0);
      check("predicted_stable", predicted, exp_pred);
   endtask

   initial begin
      logic [25:0][VAL_W-1:0] saved;
      logic [4:0] rl, rp;
      bit rt;
      int aborted_done;

      tbl[0] = '{5'd7,  1'b1, 8'd0,  5'd7,  5'd7,  8'd200, 5'd7,  1'b1};
      tbl[1] = '{5'd3,  1'b0, 8'd10, 5'd12, 5'd12, 8'd90,  5'd12, 1'b0};
      tbl[2] = '{5'd4,  1'b0, 8'h55, 5'd0,  5'd0,  8'h55,  5'd0,  1'b0};
      tbl[3] = '{5'd5,  1'b1, 8'd1,  5'd5,  5'd20, 8'd200, 5'd5,  1'b1};
      tbl[4] = '{5'd25, 1'b0, 8'd3,  5'd25, 5'd25, 8'd255, 5'd25, 1'b1};
      tbl[5] = '{5'd0,  1'b1, 8'd0,  5'd0,  5'd0,  8'd1,   5'd0,  1'b1};

      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_valid", valid, 0);
      check("rst_learn", learn, 0);
      check("rst_done", done, 0);
      check("rst_predicted", predicted, 0);
      check_vec("rst_expected_out", exp_out, '0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_counts", {sample_count, correct_count}, 0);

      for (int t = 0; t < 6; t++) begin
         set_pattern(tbl[t].base, tbl[t].p1, tbl[t].p2, tbl[t].pv);
         run_sample(tbl[t].lab, tbl[t].tr, 0, 1'b0, tbl[t].exp_pred, tbl[t].exp_corr);
      end

      for (int r = 0; r < 10; r++) begin
         for (int i = 0; i < 26; i++) layer[i] = 8'($urandom_range(0, (r < 5) ? 15 : 255));
         rl = 5'($urandom_range(0, 25));
         rt = 1'($urandom_range(0, 1));
         rp = model_argmax(layer);
         if (r == 3) rl = rp;
         run_sample(rl, rt, 0, 1'b0, rp, rl == rp);
      end

      // Out-of-range label: error pulse, nothing latched.
      saved = exp_out;
      @(negedge clk);
      start = 1'b1; label = 5'd26; train = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("label_err_pulse", label_err, 1);
      check("label_err_busy", busy, 0);
      check_vec("label_err_expected_out", exp_out, saved);
      @(negedge clk);
      check("label_err_one_cycle", label_err, 0);
      check("label_err_still_idle", busy, 0);

      // Start while busy is ignored.
      set_pattern(8'd0, 5'd9, 5'd9, 8'd77);
      run_sample(5'd9, 1'b0, 6, 1'b0, 5'd9, 1'b1);

      // Asynchronous reset in the middle of a scan.
      set_pattern(8'd2, 5'd14, 5'd14, 8'd99);
      @(negedge clk);
      start = 1'b1; label = 5'd14; train = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      check("scan_valid_before_reset", valid, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_valid", valid, 0);
      check("async_learn", learn, 0);
      check("async_busy", busy, 0);
      check_vec("async_expected_out", exp_out, '0);
      m_samples = 0; m_correct = 0;
      aborted_done = 0;
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         if (done === 1'b1) aborted_done++;
      end
      rst_n = 1'b1;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         if (done === 1'b1) aborted_done++;
      end
      check("aborted_no_done", aborted_done, 0);
      run_sample(5'd14, 1'b1, 0, 1'b0, 5'd14, 1'b1);

      // Saturation with 20 correct samples, then clear coincident with DONE.
      for (int s = 0; s < 20; s++) begin
         rl = 5'((s * 7) % 26);
         set_pattern(8'd5, rl, rl, 8'd180);
         run_sample(rl, s[0], 0, 1'b0, rl, 1'b1);
      end
      check("sat_sample_count", sample_count, exp_cnt(15));
      check("sat_correct_count", correct_count, exp_cnt(15));
      set_pattern(8'd5, 5'd11, 5'd11, 8'd180);
      run_sample(5'd11, 1'b0, 0, 1'b1, 5'd11, 1'b1);
      check("clr_sample_count", sample_count, 0);
      check("clr_correct_count", correct_count, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
